// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, fetches from ROM and buffers {pc, inst} in a FIFO.
// Optional feature macro: IF_ADEF_CHECK_EN (address-error entries on unaligned redirect).
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h1c00_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_inst_en,
   output logic [31:0] rom_inst_addr,
   input  logic [31:0] rom_inst,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
`ifdef IF_ADEF_CHECK_EN
   ,
   output logic        if_adef
`endif
);

   localparam int          AW    = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

   logic [31:0]   pc;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   pc_mem   [FIFO_DEPTH];
   logic [31:0]   inst_mem [FIFO_DEPTH];

   logic        room;
   logic        stall;
   logic        push;
   logic        pop;
   logic [31:0] push_inst;

   assign room = count < DEPTH;

`ifdef IF_ADEF_CHECK_EN
   logic halt;
   logic adef_pend;
   logic adef_push;
   logic adef_mem [FIFO_DEPTH];

   // The error entry is injected once, without a ROM request.
   assign stall     = halt;
   assign adef_push = adef_pend && !rst && !redirect_en && room;
   assign push      = rom_inst_en || adef_push;
   assign push_inst = adef_push ? 32'h0 : rom_inst;
   assign if_adef   = adef_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         adef_mem[wr_ptr] <= adef_push;
   end
`else
   assign stall     = 1'b0;
   assign push      = rom_inst_en;
   assign push_inst = rom_inst;
`endif

   assign rom_inst_en   = !rst && !redirect_en && room && !stall;
   assign rom_inst_addr = pc;
   assign if_valid      = !rst && !redirect_en && (count != '0);
   assign pop           = if_valid && id_ready;
   assign if_pc         = pc_mem[rd_ptr];
   assign if_inst       = inst_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= pc;
         inst_mem[wr_ptr] <= push_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
`ifdef IF_ADEF_CHECK_EN
         halt      <= 1'b0;
         adef_pend <= 1'b0;
`endif
      end else if (redirect_en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
`ifdef IF_ADEF_CHECK_EN
         pc        <= redirect_pc;
         halt      <= |redirect_pc[1:0];
         adef_pend <= |redirect_pc[1:0];
`else
         pc <= redirect_pc & 32'hFFFF_FFFC;
`endif
      end else begin
         if (rom_inst_en)
            pc <= pc + 32'd4;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
`ifdef IF_ADEF_CHECK_EN
         if (adef_push)
            adef_pend <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table plus redirect corner sequences.
module tb_inst_fetch;

   localparam logic [31:0] KEY = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_inst_en;
   logic [31:0] rom_inst_addr;
   logic [31:0] rom_inst;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
`ifdef IF_ADEF_CHECK_EN
   logic        if_adef;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // ROM word is a fixed function of its address.
   assign rom_inst = rom_inst_addr ^ KEY;

   inst_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .rom_inst_en   (rom_inst_en),
      .rom_inst_addr (rom_inst_addr),
      .rom_inst      (rom_inst),
      .redirect_en   (redirect_en),
      .redirect_pc   (redirect_pc),
      .id_ready      (id_ready),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_inst       (if_inst)
`ifdef IF_ADEF_CHECK_EN
      ,
      .if_adef       (if_adef)
`endif
   );

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        en;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic rd, input logic [31:0] rp,
                      input logic ry, input logic e, input logic [31:0] a,
                      input logic v, input logic [31:0] p);
      vec_t t;
      t.rst = r; t.redir = rd; t.rpc = rp; t.rdy = ry;
      t.en = e; t.addr = a; t.valid = v; t.pc = p;
      tbl.push_back(t);
   endtask

   initial begin
      // reset and stream with id_ready high
      add(1, 0, 0, 1, 0, 32'h1c000000, 0, 0);
      add(0, 0, 0, 1, 1, 32'h1c000000, 0, 0);
      add(0, 0, 0, 1, 1, 32'h1c000004, 1, 32'h1c000000);
      add(0, 0, 0, 1, 1, 32'h1c000008, 1, 32'h1c000004);
      // reset, then stall decode for 8 cycles
      add(1, 0, 0, 0, 0, 32'h1c00000c, 0, 0);
      add(0, 0, 0, 0, 1, 32'h1c000000, 0, 0);
      add(0, 0, 0, 0, 1, 32'h1c000004, 1, 32'h1c000000);
      add(0, 0, 0, 0, 1, 32'h1c000008, 1, 32'h1c000000);
      add(0, 0, 0, 0, 1, 32'h1c00000c, 1, 32'h1c000000);
      for (int i = 0; i < 4; i++)
         add(0, 0, 0, 0, 0, 32'h1c000010, 1, 32'h1c000000);
      // drain
      add(0, 0, 0, 1, 0, 32'h1c000010, 1, 32'h1c000000);
      add(0, 0, 0, 1, 1, 32'h1c000010, 1, 32'h1c000004);
      add(0, 0, 0, 1, 1, 32'h1c000014, 1, 32'h1c000008);
      add(0, 0, 0, 1, 1, 32'h1c000018, 1, 32'h1c00000c);
      add(0, 0, 0, 1, 1, 32'h1c00001c, 1, 32'h1c000010);
      // redirect with 3 buffered entries
      add(0, 1, 32'h1c000100, 1, 0, 32'h1c000020, 0, 0);
      add(0, 0, 0, 1, 1, 32'h1c000100, 0, 0);
      add(0, 0, 0, 1, 1, 32'h1c000104, 1, 32'h1c000100);
      add(0, 0, 0, 1, 1, 32'h1c000108, 1, 32'h1c000104);
      // PC wrap
      add(0, 1, 32'hfffffff8, 1, 0, 32'h1c00010c, 0, 0);
      add(0, 0, 0, 1, 1, 32'hfffffff8, 0, 0);
      add(0, 0, 0, 1, 1, 32'hfffffffc, 1, 32'hfffffff8);
      add(0, 0, 0, 1, 1, 32'h00000000, 1, 32'hfffffffc);
      add(0, 0, 0, 1, 1, 32'h00000004, 1, 32'h00000000);
      // fill, then reset pulse while full
      add(0, 0, 0, 0, 1, 32'h00000008, 1, 32'h00000004);
      add(0, 0, 0, 0, 1, 32'h0000000c, 1, 32'h00000004);
      add(0, 0, 0, 0, 1, 32'h00000010, 1, 32'h00000004);
      add(0, 0, 0, 0, 0, 32'h00000014, 1, 32'h00000004);
      add(1, 0, 0, 0, 0, 32'h00000014, 0, 0);
      add(0, 0, 0, 0, 1, 32'h1c000000, 0, 0);
      add(0, 0, 0, 1, 1, 32'h1c000004, 1, 32'h1c000000);

      rst = 1'b1;
      redirect_en = 1'b0;
      redirect_pc = '0;
      id_ready = 1'b0;
      tick();

      foreach (tbl[i]) begin
         rst         = tbl[i].rst;
         redirect_en = tbl[i].redir;
         redirect_pc = tbl[i].rpc;
         id_ready    = tbl[i].rdy;
         #3;
         chk($sformatf("v%0d en", i), 32'(rom_inst_en), 32'(tbl[i].en));
         chk($sformatf("v%0d addr", i), rom_inst_addr, tbl[i].addr);
         chk($sformatf("v%0d valid", i), 32'(if_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            chk($sformatf("v%0d pc", i), if_pc, tbl[i].pc);
            chk($sformatf("v%0d inst", i), if_inst, tbl[i].pc ^ KEY);
         end
         tick();
      end

`ifdef IF_ADEF_CHECK_EN
      id_ready = 1'b0;
      redirect_en = 1'b1;
      redirect_pc = 32'h1c000102;
      tick();
      redirect_en = 1'b0;
      #3;
      chk("adef en0", 32'(rom_inst_en), 32'h0);
      chk("adef addr", rom_inst_addr, 32'h1c000102);
      tick();
      #3;
      chk("adef valid", 32'(if_valid), 32'h1);
      chk("adef pc", if_pc, 32'h1c000102);
      chk("adef inst", if_inst, 32'h0);
      chk("adef flag", 32'(if_adef), 32'h1);
      chk("adef en1", 32'(rom_inst_en), 32'h0);
      id_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         #3;
         chk("halt en", 32'(rom_inst_en), 32'h0);
         chk("halt valid", 32'(if_valid), 32'h0);
         tick();
      end
      redirect_en = 1'b1;
      redirect_pc = 32'h1c000200;
      tick();
      redirect_en = 1'b0;
      #3;
      chk("resume en", 32'(rom_inst_en), 32'h1);
      chk("resume addr", rom_inst_addr, 32'h1c000200);
      tick();
      #3;
      chk("resume pc", if_pc, 32'h1c000200);
      chk("resume valid", 32'(if_valid), 32'h1);
      chk("resume flag", 32'(if_adef), 32'h0);
      tick();
`else
      id_ready = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 32'h1c000103;
      tick();
      redirect_en = 1'b0;
      #3;
      chk("align en", 32'(rom_inst_en), 32'h1);
      chk("align addr", rom_inst_addr, 32'h1c000100);
      chk("align valid0", 32'(if_valid), 32'h0);
      tick();
      #3;
      chk("align valid", 32'(if_valid), 32'h1);
      chk("align pc", if_pc, 32'h1c000100);
      chk("align inst", if_inst, 32'h1c000100 ^ KEY);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
